// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Holds the register offsets within the 16-byte window, the STATUS bit
// layout, and the transmit FSM state encoding.
package uart_pkg;

  localparam logic [3:0] REG_TXDATA   = 4'h0;
  localparam logic [3:0] REG_STATUS   = 4'h4;
  localparam logic [3:0] REG_BAUD_DIV = 4'h8;

  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_OVERFLOW  = 3;
  localparam int STAT_COUNT_LSB = 4;
  localparam int STAT_COUNT_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and a fall-through head.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   push, push_data     write request and data
//   push_drop           push requested but refused (full, no pop this cycle)
//   pop, pop_data       read request; pop_data is the current head
//   full, empty, count  occupancy flags and entry count
// A push while full is accepted when a pop happens in the same cycle, so the
// count stays unchanged in that case.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  output logic                   push_drop,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign push_drop = push && !do_push;
  assign pop_data  = mem[rd_ptr];

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter sitting beside dmem on the data bus.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   ip_data_addr/wr/rd      processor byte address and strobes
//   ip_data_mask            byte-lane enables for writes
//   ip_data_from_proc       write data
//   op_data_valid           one-cycle acknowledge, one cycle after a hit
//   op_data_from_uart       registered read data, zero without an ack
//   op_tx                   serial line, idle high
//
// state   | meaning
// IDLE    | line high; pops the FIFO head and starts a frame when available
// START   | start bit (low) for div cycles
// DATA    | 8 data bits LSB first, div cycles each
// STOP    | stop bit (high) for div cycles
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_1000,
  parameter int          FIFO_DEPTH     = 4,
  parameter logic [15:0] RESET_BAUD_DIV = 16'd16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ip_data_addr,
  input  logic        ip_data_wr,
  input  logic [3:0]  ip_data_mask,
  input  logic [31:0] ip_data_from_proc,
  input  logic        ip_data_rd,
  output logic        op_data_valid,
  output logic [31:0] op_data_from_uart,
  output logic        op_tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [3:0]  offset;
  logic        hit, wr_hit, rd_hit;
  logic        push_req, status_rd;
  logic [31:0] rd_mux;
  logic [15:0] baud_div, div_eff, div_lat, baud_cnt;
  logic        overflow;
  logic        busy;

  logic          fifo_pop, fifo_full, fifo_empty, fifo_drop;
  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_count;

  tx_state_t   state, state_next;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        baud_tc;

  // Upper data bits and lanes 2..3 have no register behind them.
  logic unused_bits;
  assign unused_bits = ^{ip_data_from_proc[31:16], ip_data_mask[3:2]};

  assign offset = ip_data_addr[3:0];
  assign hit    = (ip_data_rd || ip_data_wr) && (ip_data_addr[31:4] == BASE_ADDR[31:4]);
  assign wr_hit = hit && ip_data_wr;
  // rd together with wr is handled as a plain write returning zero.
  assign rd_hit = hit && ip_data_rd && !ip_data_wr;

  assign push_req  = wr_hit && (offset == REG_TXDATA) && ip_data_mask[0];
  assign status_rd = rd_hit && (offset == REG_STATUS);

  assign div_eff  = (baud_div == 16'd0) ? 16'd1 : baud_div;
  assign baud_tc  = (baud_cnt == 16'd0);
  assign fifo_pop = (state == ST_IDLE) && !fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_req),
    .push_data (ip_data_from_proc[7:0]),
    .push_drop (fifo_drop),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    rd_mux = '0;
    case (offset)
      REG_STATUS: begin
        rd_mux[STAT_FULL]     = fifo_full;
        rd_mux[STAT_EMPTY]    = fifo_empty;
        rd_mux[STAT_BUSY]     = busy;
        rd_mux[STAT_OVERFLOW] = overflow;
        rd_mux[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);
      end
      REG_BAUD_DIV: rd_mux[15:0] = baud_div;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_data_valid     <= 1'b0;
      op_data_from_uart <= '0;
      baud_div          <= RESET_BAUD_DIV;
      overflow          <= 1'b0;
    end else begin
      op_data_valid     <= hit;
      op_data_from_uart <= rd_hit ? rd_mux : '0;
      if (wr_hit && (offset == REG_BAUD_DIV)) begin
        if (ip_data_mask[0]) baud_div[7:0]  <= ip_data_from_proc[7:0];
        if (ip_data_mask[1]) baud_div[15:8] <= ip_data_from_proc[15:8];
      end
      // A drop in the same cycle as a STATUS read keeps the flag set.
      if (fifo_drop)      overflow <= 1'b1;
      else if (status_rd) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (!fifo_empty)                 state_next = ST_START;
      ST_START: if (baud_tc)                     state_next = ST_DATA;
      ST_DATA:  if (baud_tc && bit_cnt == 3'd7)  state_next = ST_STOP;
      ST_STOP:  if (baud_tc)                     state_next = ST_IDLE;
      default:                                   state_next = ST_IDLE;
    endcase
  end

  // Divider is captured at frame start so BAUD_DIV writes only affect later frames.
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      div_lat  <= 16'd1;
    end else begin
      case (state)
        ST_IDLE: if (!fifo_empty) begin
          shift    <= fifo_head;
          bit_cnt  <= '0;
          baud_cnt <= div_eff - 16'd1;
          div_lat  <= div_eff;
        end
        ST_START: baud_cnt <= baud_tc ? div_lat - 16'd1 : baud_cnt - 16'd1;
        ST_DATA: begin
          if (baud_tc) begin
            baud_cnt <= div_lat - 16'd1;
            shift    <= shift >> 1;
            bit_cnt  <= bit_cnt + 3'd1;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        ST_STOP: if (!baud_tc) baud_cnt <= baud_cnt - 16'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    op_tx = 1'b1;
    busy  = (state != ST_IDLE);
    case (state)
      ST_START: op_tx = 1'b0;
      ST_DATA:  op_tx = shift[0];
      default:  op_tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed bus steps plus randomized byte streams,
// with a line monitor that decodes frames and a queue-based expectation.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] A_TX  = BASE + 32'h0;
  localparam logic [31:0] A_ST  = BASE + 32'h4;
  localparam logic [31:0] A_BD  = BASE + 32'h8;
  localparam logic [31:0] A_RSV = BASE + 32'hC;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ip_data_addr;
  logic        ip_data_wr;
  logic [3:0]  ip_data_mask;
  logic [31:0] ip_data_from_proc;
  logic        ip_data_rd;
  logic        op_data_valid;
  logic [31:0] op_data_from_uart;
  logic        op_tx;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int mon_div = 16;

  logic [10:0] rx_q[$];
  int          start_q[$];

  mmio_uart_tx #(
    .BASE_ADDR      (BASE),
    .FIFO_DEPTH     (DEPTH),
    .RESET_BAUD_DIV (16'd16)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .ip_data_addr      (ip_data_addr),
    .ip_data_wr        (ip_data_wr),
    .ip_data_mask      (ip_data_mask),
    .ip_data_from_proc (ip_data_from_proc),
    .ip_data_rd        (ip_data_rd),
    .op_data_valid     (op_data_valid),
    .op_data_from_uart (op_data_from_uart),
    .op_tx             (op_tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: on each falling edge from idle, sample 10 bit slots of
  // mon_div cycles; bit 10 of the record flags a level change inside a slot.
  initial begin : monitor
    logic       prev;
    logic [9:0] obs;
    logic       jit;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && op_tx === 1'b0) begin
        start_q.push_back(cyc);
        obs = '0;
        jit = 1'b0;
        for (int k = 0; k < 10; k++) begin
          for (int c = 0; c < mon_div; c++) begin
            if (k != 0 || c != 0) @(negedge clk);
            if (c == 0) obs[k] = op_tx;
            else if (op_tx !== obs[k]) jit = 1'b1;
          end
        end
        rx_q.push_back({jit, obs});
      end
      prev = op_tx;
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    return {1'b0, 1'b1, b, 1'b0};
  endfunction

  function automatic logic [31:0] status_of(input bit full, input bit empty, input bit busy,
                                            input bit ovf, input int count);
    logic [31:0] s;
    s = 32'(count) << 4;
    s[0] = full;
    s[1] = empty;
    s[2] = busy;
    s[3] = ovf;
    return s;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bus tasks start and end on a falling edge so calls can run back to back.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] mask, input bit exp_ack, input string tag);
    ip_data_addr      = addr;
    ip_data_from_proc = data;
    ip_data_mask      = mask;
    ip_data_wr        = 1'b1;
    ip_data_rd        = 1'b0;
    @(negedge clk);
    ip_data_wr   = 1'b0;
    ip_data_mask = 4'h0;
    check({tag, "_ack"}, 32'(op_data_valid), 32'(exp_ack));
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] d,
                          input bit exp_ack, input string tag);
    ip_data_addr = addr;
    ip_data_rd   = 1'b1;
    ip_data_wr   = 1'b0;
    @(negedge clk);
    ip_data_rd = 1'b0;
    d = op_data_from_uart;
    check({tag, "_ack"}, 32'(op_data_valid), 32'(exp_ack));
  endtask

  task automatic wait_frames(input int n, input int budget, input string tag);
    int t;
    t = 0;
    while (rx_q.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_nframes"}, 32'(rx_q.size()), 32'(n));
  endtask

  task automatic check_frames(input logic [7:0] exp_q[$], input string tag);
    logic [10:0] got;
    foreach (exp_q[i]) begin
      got = (rx_q.size() > 0) ? rx_q.pop_front() : 11'h7FF;
      check($sformatf("%s_frame%0d", tag, i), 32'(got), 32'(frame_of(exp_q[i])));
    end
  endtask

  initial begin : stimulus
    logic [31:0] d;
    logic [7:0]  exp_q[$];
    int          wr_cyc;
    int          div;
    int          n;
    int          lows;
    logic [7:0]  b;

    reset             = 1'b1;
    ip_data_addr      = '0;
    ip_data_wr        = 1'b0;
    ip_data_mask      = 4'h0;
    ip_data_from_proc = '0;
    ip_data_rd        = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state and STATUS read/ack timing.
    idle(5);
    check("rst_tx", 32'(op_tx), 32'd1);
    check("rst_valid", 32'(op_data_valid), 32'd0);
    check("rst_rdata", op_data_from_uart, 32'd0);
    bus_read(A_ST, d, 1'b1, "rst_status");
    check("rst_status", d, status_of(0, 1, 0, 0, 0));
    idle(1);
    check("ack_one_cycle", 32'(op_data_valid), 32'd0);
    check("rdata_zero_no_ack", op_data_from_uart, 32'd0);
    bus_read(A_BD, d, 1'b1, "rst_baud");
    check("rst_baud", d, 32'd16);

    // Single frame 0xA5 at div 4, with latency and busy checks.
    bus_write(A_BD, 32'hFFFF_0004, 4'b0011, 1'b1, "baud4");
    bus_read(A_BD, d, 1'b1, "baud4_rb");
    check("baud4_rb", d, 32'd4);
    mon_div = 4;
    rx_q.delete();
    start_q.delete();
    bus_write(A_TX, 32'h0000_00A5, 4'b0001, 1'b1, "tx_a5");
    wr_cyc = cyc;
    check("lat_edge_n", 32'(op_tx), 32'd1);
    @(negedge clk);
    check("lat_edge_n1", 32'(op_tx), 32'd0);
    for (int i = 0; i < 4; i++) begin
      idle(6);
      bus_read(A_ST, d, 1'b1, "busy");
      check($sformatf("busy_%0d", i), d, status_of(0, 1, 1, 0, 0));
    end
    wait_frames(1, 200, "a5");
    exp_q = '{8'hA5};
    check_frames(exp_q, "a5");
    check("a5_latency", 32'((start_q.size() > 0) ? start_q[0] - wr_cyc : -1), 32'd1);
    idle(2);
    bus_read(A_ST, d, 1'b1, "a5_done");
    check("a5_done", d, status_of(0, 1, 0, 0, 0));

    // Six back-to-back bytes at div 2: one goes straight out, DEPTH queue, rest drop.
    bus_write(A_BD, 32'h0000_0002, 4'b0011, 1'b1, "baud2");
    mon_div = 2;
    rx_q.delete();
    start_q.delete();
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      bus_write(A_TX, {24'h0, b}, 4'b0001, 1'b1, "burst");
      if (i == 0) wr_cyc = cyc;
      if (i < DEPTH + 1) exp_q.push_back(b);
    end
    bus_read(A_ST, d, 1'b1, "ovf1");
    check("ovf_set", d, status_of(1, 0, 1, 1, DEPTH));
    bus_read(A_ST, d, 1'b1, "ovf2");
    check("ovf_cleared", d, status_of(1, 0, 1, 0, DEPTH));
    wait_frames(DEPTH + 1, 400, "burst");
    check_frames(exp_q, "burst");
    check("burst_latency", 32'((start_q.size() > 0) ? start_q[0] - wr_cyc : -1), 32'd1);
    for (int i = 1; i < start_q.size(); i++)
      check($sformatf("burst_gap%0d", i), 32'(start_q[i] - start_q[i-1]), 32'(10 * 2 + 1));
    idle(2);
    bus_read(A_ST, d, 1'b1, "burst_done");
    check("burst_done", d, status_of(0, 1, 0, 0, 0));

    // Lane-masked BAUD_DIV writes, then divider 0 acts as 1.
    bus_write(A_BD, 32'h0000_AB12, 4'b0001, 1'b1, "lane0");
    bus_read(A_BD, d, 1'b1, "lane0_rb");
    check("lane0_rb", d, 32'h0000_0012);
    bus_write(A_BD, 32'hFFFF_CD99, 4'b0010, 1'b1, "lane1");
    bus_read(A_BD, d, 1'b1, "lane1_rb");
    check("lane1_rb", d, 32'h0000_CD12);
    bus_write(A_BD, 32'h0000_0000, 4'b0011, 1'b1, "baud0");
    bus_read(A_BD, d, 1'b1, "baud0_rb");
    check("baud0_rb", d, 32'd0);
    mon_div = 1;
    rx_q.delete();
    start_q.delete();
    bus_write(A_TX, 32'h0000_0001, 4'b0001, 1'b1, "tx01");
    wait_frames(1, 50, "div0");
    exp_q = '{8'h01};
    check_frames(exp_q, "div0");
    idle(2);

    // Randomized streams with random divider; all fit without overflow.
    for (int r = 0; r < 4; r++) begin
      div = $urandom_range(1, 3);
      n   = $urandom_range(1, DEPTH + 1);
      bus_write(A_BD, 32'(div), 4'b0011, 1'b1, "rnd_baud");
      mon_div = div;
      rx_q.delete();
      start_q.delete();
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        bus_write(A_TX, {$urandom} & 32'hFFFF_FF00 | 32'(b), 4'b0001, 1'b1, "rnd_tx");
      end
      wait_frames(n, 100 * n * div + 50, $sformatf("rnd%0d", r));
      check_frames(exp_q, $sformatf("rnd%0d", r));
      idle(2);
      bus_read(A_ST, d, 1'b1, "rnd_done");
      check($sformatf("rnd%0d_status", r), d, status_of(0, 1, 0, 0, 0));
    end

    // Misses, masked TXDATA write, rd+wr together, reserved offset.
    rx_q.delete();
    start_q.delete();
    bus_read(BASE + 32'h100, d, 1'b0, "miss_rd");
    check("miss_rdata", d, 32'd0);
    bus_write(BASE + 32'h100, 32'h55, 4'b0001, 1'b0, "miss_wr");
    bus_write(A_TX, 32'hFF, 4'b1110, 1'b1, "masked_tx");
    ip_data_addr = A_ST;
    ip_data_rd   = 1'b1;
    ip_data_wr   = 1'b1;
    ip_data_mask = 4'hF;
    ip_data_from_proc = 32'hFFFF_FFFF;
    @(negedge clk);
    ip_data_rd   = 1'b0;
    ip_data_wr   = 1'b0;
    ip_data_mask = 4'h0;
    check("rdwr_ack", 32'(op_data_valid), 32'd1);
    check("rdwr_data", op_data_from_uart, 32'd0);
    bus_read(A_RSV, d, 1'b1, "rsv");
    check("rsv_data", d, 32'd0);
    bus_read(A_ST, d, 1'b1, "masked_status");
    check("masked_status", d, status_of(0, 1, 0, 0, 0));
    idle(20);
    check("masked_no_frame", 32'(rx_q.size()), 32'd0);

    // Reset during data bit 3 with two bytes still queued.
    bus_write(A_BD, 32'h0000_0004, 4'b0011, 1'b1, "baud4b");
    mon_div = 4;
    bus_write(A_TX, 32'h35, 4'b0001, 1'b1, "rst_tx0");
    bus_write(A_TX, 32'h0F, 4'b0001, 1'b1, "rst_tx1");
    bus_write(A_TX, 32'hF0, 4'b0001, 1'b1, "rst_tx2");
    idle(16);
    check("pre_rst_bit3", 32'(op_tx), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("midframe_rst_tx", 32'(op_tx), 32'd1);
    reset = 1'b0;
    bus_read(A_ST, d, 1'b1, "post_rst");
    check("post_rst_status", d, status_of(0, 1, 0, 0, 0));
    lows = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (op_tx !== 1'b1) lows++;
    end
    check("post_rst_no_frames", 32'(lows), 32'd0);
    rx_q.delete();
    start_q.delete();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
